rl_ram_1r1w_arb: RTL and testbench
==================================

RL_RAM_1R1W_ARB -- requirements
Module: rl_ram_1r1w_arb

Interface
REQ-001 SHALL have parameter ABITS, default 10: RAM address width.
REQ-002 SHALL have parameter DBITS, default 32: data width; byte-enable width BEW = (DBITS+7)/8.
REQ-003 SHALL have parameter NREQ, default 4: requester count, 2..16.
REQ-004 SHALL have parameter HAZARD, default 1: when 1, a read colliding with a same-cycle granted write is deferred.
REQ-005 SHALL have port clk  in  1: single clock, rising edge.
REQ-006 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-007 SHALL have port wreq  in  NREQ: per-requester write request.
REQ-008 SHALL have port waddr/wdin/wbe  in  NREQ*ABITS / NREQ*DBITS / NREQ*BEW: flattened write fields, requester i at slice i.
REQ-009 SHALL have port wgnt  out  NREQ: one-hot-or-zero write acceptance, same cycle.
REQ-010 SHALL have port rreq  in  NREQ: per-requester read request.
REQ-011 SHALL have port raddr  in  NREQ*ABITS: flattened read addresses.
REQ-012 SHALL have port rgnt  out  NREQ: one-hot-or-zero read acceptance, same cycle.
REQ-013 SHALL have ports rvalid  out  NREQ and rdata  out  DBITS: one-hot read response and its data.
REQ-014 SHALL have RAM-side ports ram_we, ram_waddr, ram_din, ram_be, ram_raddr (out) and ram_dout (in, DBITS, registered, one-cycle latency, no write bypass).

Function
REQ-015 SHALL arbitrate write and read ports independently, each round-robin; a request is accepted when gnt and req are both high.
REQ-016 SHALL make the requester at the priority pointer highest priority; after a grant to i, the pointer SHALL become (i+1) mod NREQ; with no grant the pointer SHALL hold.
REQ-017 SHALL drive ram_we = |wgnt, with ram_waddr/ram_din/ram_be muxed combinationally from the granted requester.
REQ-018 SHALL drive ram_raddr from the granted read requester; when no read is granted it SHALL hold the last granted address.
REQ-019 SHALL assert rvalid[i] in cycle N+1 for a read granted to i in cycle N, with rdata = ram_dout in that cycle; otherwise rvalid = 0.
REQ-020 SHALL, when HAZARD=1 and the read winner's address equals a same-cycle granted write address, withhold rgnt and leave the read pointer unchanged; the read SHALL win the next arbitration and return the new data.
REQ-021 SHALL, when HAZARD=0, grant colliding reads normally; the returned data is the pre-write content.
REQ-022 SHALL grant a continuously held request within NREQ grant cycles of its port (no starvation).
REQ-023 SHALL accept requesters that drop req without a grant; no state is kept for them.

Reset
REQ-024 SHALL, while rst is high, force wgnt=0, rgnt=0, ram_we=0, rvalid=0, both pointers=0 and ram_raddr=0.
REQ-025 SHALL discard a read granted in the cycle in which rst asserts; no rvalid SHALL follow.
REQ-026 SHALL treat rdata as unreset (RAM data); the bench SHALL check rdata only when rvalid is nonzero.

Structure
REQ-027 SHALL place BEW computation and a requester-index typedef (width $clog2(NREQ)) in shared package rl_ram_pkg.
REQ-028 SHALL instantiate sub-module rl_rr_arbiter (req, gnt, pointer update enable) twice, for the write and read ports.
REQ-029 SHALL contain no memory array; storage is external.

Verification (NREQ=4, ABITS=4, DBITS=32, RAM model attached)
REQ-030 SHALL cover: rst high with wreq=rreq=1111 -> wgnt=rgnt=0000, rvalid=0000; first cycle after release -> wgnt=0001, rgnt=0001.
REQ-031 SHALL cover: wreq=1111 held 5 cycles -> wgnt 0001,0010,0100,1000,0001.
REQ-032 SHALL cover: req0 writes addr 3 = 0xDEADBEEF, be=1111; next cycle req2 reads addr 3 -> following cycle rvalid=0100, rdata=0xDEADBEEF.
REQ-033 SHALL cover: req1 writes addr 3 = 0x11223344, be=0101, then a read of addr 3 -> rdata=0xDE22BE44.
REQ-034 SHALL cover: HAZARD=1, same cycle write addr 5 = 0xA5A5A5A5 and read addr 5 -> rgnt=0000 that cycle, granted next cycle, rdata=0xA5A5A5A5; HAZARD=0 -> granted immediately, old data returned.
REQ-035 SHALL cover: read granted in cycle N, rst asserted before edge N+1 -> rvalid=0000 in N+1; pointers = 0.

Source files
------------

// File: rtl/rl_ram_pkg.sv
// rl_ram_pkg
// Purpose : shared types and helpers for the arbitrated 1R1W RAM front end.
// Contents: NREQ_MAX  - largest supported requester count
//           req_idx_t - requester index, wide enough for every supported count
//           bew_of()  - byte-enable width for a given data width
package rl_ram_pkg;

    localparam int unsigned NREQ_MAX = 16;

    // Sized for the largest requester count so that one type serves every
    // parameterisation; smaller NREQ values simply never reach the top codes.
    typedef logic [$clog2(NREQ_MAX)-1:0] req_idx_t;

    function automatic int unsigned bew_of(input int unsigned dbits);
        return (dbits + 7) / 8;
    endfunction

endpackage

// File: rtl/rl_rr_arbiter.sv
// rl_rr_arbiter
// Purpose : round-robin arbiter with a registered priority pointer.
// Ports   : clk, rst      - clock, async active-high reset
//           req[N]        - request vector
//           en            - allow a grant and the pointer update this cycle
//           gnt[N]        - one-hot-or-zero grant (combinational)
//           win_vld       - some request is pending (independent of en)
//           win_idx       - index of the highest-priority pending request
module rl_rr_arbiter
    import rl_ram_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic         win_vld,
    output req_idx_t     win_idx
);

    req_idx_t r_ptr;

    // First pass looks at requesters at or above the pointer; if none is
    // pending, the lowest pending index overall wraps around.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!win_vld && req[i] && (req_idx_t'(i) >= r_ptr)) begin
                win_vld = 1'b1;
                win_idx = req_idx_t'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!win_vld && req[i]) begin
                win_vld = 1'b1;
                win_idx = req_idx_t'(i);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = en && win_vld && (win_idx == req_idx_t'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en && win_vld) begin
            r_ptr <= (win_idx == req_idx_t'(N - 1)) ? '0 : win_idx + req_idx_t'(1);
        end
    end

endmodule

// File: rtl/rl_ram_1r1w_arb.sv
// rl_ram_1r1w_arb
// Purpose : arbitrates NREQ write and NREQ read requesters onto one external
//           1R1W RAM (registered read, one-cycle latency, no write bypass).
// Ports   : clk, rst                 - clock, async active-high reset
//           wreq/waddr/wdin/wbe      - per-requester write fields (flattened)
//           wgnt                     - write acceptance, same cycle
//           rreq/raddr               - per-requester read fields (flattened)
//           rgnt                     - read acceptance, same cycle
//           rvalid/rdata             - read response, one cycle after rgnt
//           ram_we/ram_waddr/ram_din/ram_be/ram_raddr/ram_dout - RAM side
module rl_ram_1r1w_arb
    import rl_ram_pkg::*;
#(
    parameter int unsigned ABITS  = 10,
    parameter int unsigned DBITS  = 32,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned HAZARD = 1,
    localparam int unsigned BEW   = bew_of(DBITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       wreq,
    input  logic [NREQ*ABITS-1:0] waddr,
    input  logic [NREQ*DBITS-1:0] wdin,
    input  logic [NREQ*BEW-1:0]   wbe,
    output logic [NREQ-1:0]       wgnt,
    input  logic [NREQ-1:0]       rreq,
    input  logic [NREQ*ABITS-1:0] raddr,
    output logic [NREQ-1:0]       rgnt,
    output logic [NREQ-1:0]       rvalid,
    output logic [DBITS-1:0]      rdata,
    output logic                  ram_we,
    output logic [ABITS-1:0]      ram_waddr,
    output logic [DBITS-1:0]      ram_din,
    output logic [BEW-1:0]        ram_be,
    output logic [ABITS-1:0]      ram_raddr,
    input  logic [DBITS-1:0]      ram_dout
);

    req_idx_t         w_widx;
    req_idx_t         w_ridx;
    logic             w_wvld;
    logic             w_rvld;
    logic             w_hazard;
    logic [ABITS-1:0] w_rd_addr;
    logic [ABITS-1:0] r_raddr;
    logic [NREQ-1:0]  r_rvalid;

    rl_rr_arbiter #(.N(NREQ)) u_warb (
        .clk     (clk),
        .rst     (rst),
        .req     (wreq),
        .en      (!rst),
        .gnt     (wgnt),
        .win_vld (w_wvld),
        .win_idx (w_widx)
    );

    // A read whose address matches this cycle's granted write is held off so
    // it samples the RAM after the write lands; its pointer stays put so it
    // is first in line next cycle.
    rl_rr_arbiter #(.N(NREQ)) u_rarb (
        .clk     (clk),
        .rst     (rst),
        .req     (rreq),
        .en      (!rst && !w_hazard),
        .gnt     (rgnt),
        .win_vld (w_rvld),
        .win_idx (w_ridx)
    );

    assign ram_we    = |wgnt;
    assign ram_waddr = waddr[int'(w_widx) * ABITS +: ABITS];
    assign ram_din   = wdin[int'(w_widx) * DBITS +: DBITS];
    assign ram_be    = wbe[int'(w_widx) * BEW +: BEW];

    assign w_rd_addr = raddr[int'(w_ridx) * ABITS +: ABITS];
    assign w_hazard  = (HAZARD != 0) && ram_we && w_rvld && (w_rd_addr == ram_waddr);

    assign ram_raddr = (|rgnt) ? w_rd_addr : r_raddr;
    assign rvalid    = r_rvalid;
    assign rdata     = ram_dout;

    // The async reset also clears a response that was launched in the cycle
    // reset arrived, so no stale rvalid escapes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raddr  <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= rgnt;
            if (|rgnt) begin
                r_raddr <= w_rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_rl_ram_1r1w_arb.sv
module tb_rl_ram_1r1w_arb;

    localparam int NREQ  = 4;
    localparam int ABITS = 4;
    localparam int DBITS = 32;
    localparam int BEW   = 4;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       wreq;
    logic [NREQ*ABITS-1:0] waddr;
    logic [NREQ*DBITS-1:0] wdin;
    logic [NREQ*BEW-1:0]   wbe;
    logic [NREQ-1:0]       rreq;
    logic [NREQ*ABITS-1:0] raddr;

    logic [NREQ-1:0]  wgnt0, rgnt0, rvalid0, wgnt1, rgnt1, rvalid1;
    logic [DBITS-1:0] rdata0, rdata1, ram_din0, ram_din1, ram_dout0, ram_dout1;
    logic             ram_we0, ram_we1;
    logic [ABITS-1:0] ram_waddr0, ram_waddr1, ram_raddr0, ram_raddr1;
    logic [BEW-1:0]   ram_be0, ram_be1;

    logic [DBITS-1:0] mem0 [16];
    logic [DBITS-1:0] mem1 [16];

    int n_chk = 0;
    int n_err = 0;

    rl_ram_1r1w_arb #(.ABITS(ABITS), .DBITS(DBITS), .NREQ(NREQ), .HAZARD(1)) dut0 (
        .clk(clk), .rst(rst),
        .wreq(wreq), .waddr(waddr), .wdin(wdin), .wbe(wbe), .wgnt(wgnt0),
        .rreq(rreq), .raddr(raddr), .rgnt(rgnt0),
        .rvalid(rvalid0), .rdata(rdata0),
        .ram_we(ram_we0), .ram_waddr(ram_waddr0), .ram_din(ram_din0), .ram_be(ram_be0),
        .ram_raddr(ram_raddr0), .ram_dout(ram_dout0)
    );

    rl_ram_1r1w_arb #(.ABITS(ABITS), .DBITS(DBITS), .NREQ(NREQ), .HAZARD(0)) dut1 (
        .clk(clk), .rst(rst),
        .wreq(wreq), .waddr(waddr), .wdin(wdin), .wbe(wbe), .wgnt(wgnt1),
        .rreq(rreq), .raddr(raddr), .rgnt(rgnt1),
        .rvalid(rvalid1), .rdata(rdata1),
        .ram_we(ram_we1), .ram_waddr(ram_waddr1), .ram_din(ram_din1), .ram_be(ram_be1),
        .ram_raddr(ram_raddr1), .ram_dout(ram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM models: the read samples the old word, no bypass.
    always @(posedge clk) begin
        ram_dout0 <= mem0[ram_raddr0];
        if (ram_we0)
            for (int b = 0; b < BEW; b++)
                if (ram_be0[b]) mem0[ram_waddr0][b*8 +: 8] <= ram_din0[b*8 +: 8];
    end

    always @(posedge clk) begin
        ram_dout1 <= mem1[ram_raddr1];
        if (ram_we1)
            for (int b = 0; b < BEW; b++)
                if (ram_be1[b]) mem1[ram_waddr1][b*8 +: 8] <= ram_din1[b*8 +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        wreq  = 4'hF;
        rreq  = 4'hF;
        waddr = {4'd15, 4'd14, 4'd13, 4'd12};
        raddr = {4'd11, 4'd10, 4'd9, 4'd8};
        wdin  = '0;
        wbe   = '0;

        // Reset holds every grant and response low
        cyc; cyc; #1;
        chk("rst_wgnt",   32'(wgnt0),      32'h0);
        chk("rst_rgnt",   32'(rgnt0),      32'h0);
        chk("rst_rvalid", 32'(rvalid0),    32'h0);
        chk("rst_ram_we", 32'(ram_we0),    32'h0);
        chk("rst_raddr",  32'(ram_raddr0), 32'h0);

        // First cycle after release: both pointers at 0
        cyc;
        rst = 1'b0;
        #1;
        chk("rel_wgnt", 32'(wgnt0), 32'h1);
        chk("rel_rgnt", 32'(rgnt0), 32'h1);

        // Write rotation with all requesters held
        cyc;
        chk("rel_rvalid", 32'(rvalid0), 32'h1);
        rreq = 4'h0;
        #1; chk("rr_wgnt_1", 32'(wgnt0), 32'h2);
        cyc; #1; chk("rr_wgnt_2", 32'(wgnt0), 32'h4);
        cyc; #1; chk("rr_wgnt_3", 32'(wgnt0), 32'h8);
        cyc; #1; chk("rr_wgnt_4", 32'(wgnt0), 32'h1);

        // req0 writes 0xDEADBEEF to addr 3
        cyc;
        wreq        = 4'h1;
        waddr[3:0]  = 4'd3;
        wdin[31:0]  = 32'hDEADBEEF;
        wbe[3:0]    = 4'hF;
        #1;
        chk("wr_wgnt",  32'(wgnt0),      32'h1);
        chk("wr_we",    32'(ram_we0),    32'h1);
        chk("wr_waddr", 32'(ram_waddr0), 32'h3);
        chk("wr_din",   ram_din0,        32'hDEADBEEF);
        chk("wr_be",    32'(ram_be0),    32'hF);

        // req2 reads addr 3
        cyc;
        wreq        = 4'h0;
        rreq        = 4'h4;
        raddr[11:8] = 4'd3;
        #1;
        chk("rd_rgnt",  32'(rgnt0),      32'h4);
        chk("rd_raddr", 32'(ram_raddr0), 32'h3);

        // Response; then req1 partial write 0x11223344 be=0101 to addr 3
        cyc;
        chk("rd_rvalid", 32'(rvalid0), 32'h4);
        chk("rd_rdata",  rdata0,       32'hDEADBEEF);
        rreq        = 4'h0;
        wreq        = 4'h2;
        waddr[7:4]  = 4'd3;
        wdin[63:32] = 32'h11223344;
        wbe[7:4]    = 4'h5;
        #1;
        chk("be_wgnt", 32'(wgnt0), 32'h2);

        cyc;
        wreq       = 4'h0;
        rreq       = 4'h1;
        raddr[3:0] = 4'd3;
        #1;
        chk("be_rgnt", 32'(rgnt0), 32'h1);

        // Merged bytes come back; then preload addr 5 with 0x01020304
        cyc;
        chk("be_rvalid", 32'(rvalid0), 32'h1);
        chk("be_rdata",  rdata0,       32'hDE22BE44);
        rreq       = 4'h0;
        wreq       = 4'h1;
        waddr[3:0] = 4'd5;
        wdin[31:0] = 32'h01020304;
        wbe[3:0]   = 4'hF;

        // Same-cycle write and read of addr 5
        cyc;
        wdin[31:0] = 32'hA5A5A5A5;
        rreq       = 4'h2;
        raddr[7:4] = 4'd5;
        #1;
        chk("hz_wgnt",   32'(wgnt0), 32'h1);
        chk("hz1_rgnt",  32'(rgnt0), 32'h0);
        chk("hz0_rgnt",  32'(rgnt1), 32'h2);

        cyc;
        chk("hz0_rvalid", 32'(rvalid1), 32'h2);
        chk("hz0_rdata",  rdata1,       32'h01020304);
        chk("hz1_norv",   32'(rvalid0), 32'h0);
        wreq = 4'h0;
        #1;
        chk("hz1_rgnt_next", 32'(rgnt0), 32'h2);

        cyc;
        chk("hz1_rvalid", 32'(rvalid0), 32'h2);
        chk("hz1_rdata",  rdata0,       32'hA5A5A5A5);

        // Read granted, then reset arrives before the next edge
        rreq       = 4'h1;
        raddr[3:0] = 4'd4;
        #1;
        chk("rr_rgnt", 32'(rgnt0), 32'h1);
        rst = 1'b1;
        #1;
        chk("rr_rgnt_rst",  32'(rgnt0),      32'h0);
        chk("rr_raddr_rst", 32'(ram_raddr0), 32'h0);
        cyc;
        chk("rr_no_rvalid", 32'(rvalid0), 32'h0);

        // Pointers were cleared: requester 0 wins both ports again
        rst   = 1'b0;
        wreq  = 4'hF;
        rreq  = 4'hF;
        waddr = {4'd15, 4'd14, 4'd13, 4'd12};
        raddr = {4'd11, 4'd10, 4'd9, 4'd8};
        wbe   = '0;
        #1;
        chk("ptr_wgnt", 32'(wgnt0), 32'h1);
        chk("ptr_rgnt", 32'(rgnt0), 32'h1);

        cyc;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
